kbd_event_writer: RTL
=====================

Name: kbd_event_writer

Overview:
- Producer side of the memory data port: takes keyboard events from the key-scan logic and writes them into a circular event buffer in data memory, then publishes the new head index at a fixed word so the CPU can poll it.
- Drives the same data port the CPU uses (`data_addr`, `data_in`, `wr_en`), with a `mem_req`/`mem_gnt` arbitration handshake in front of it.
- The CPU is the consumer: it reads entries and reports its read index back on `cons_ptr`.

Parameters:
- `BUF_BASE`, `32'h0000_1000`: byte address of entry 0; word aligned.
- `BUF_DEPTH`, `16`: number of entries; must be a power of 2 and at least 4.
- `HEAD_ADDR`, `32'h0000_0FFC`: byte address of the published head word.
- `PTR_W`, `$clog2(BUF_DEPTH)`: width of the buffer indices.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `key_valid`  in  1  event offered.
- `key_code`  in  8  scan code.
- `key_pressed`  in  1  1 = make, 0 = break.
- `key_ready`  out  1  event accepted when `key_valid && key_ready` at posedge.
- `cons_ptr`  in  PTR_W  CPU read index.
- `mem_req`  out  1  request for the data port.
- `mem_gnt`  in  1  grant from the arbiter.
- `data_addr`  out  32  write byte address.
- `data_in`  out  32  write data.
- `wr_en`  out  1  memory write strobe.
- `head_ptr`  out  PTR_W  next slot to write.
- `overflow_cnt`  out  8  dropped-event count.

Behaviour:
- Reset: async assert forces all of the following, regardless of FSM state; no partial-write recovery.
  - state = IDLE; `head_ptr` = 0; `overflow_cnt` = 0.
  - `mem_req` = 0, `wr_en` = 0, `data_addr` = 0, `data_in` = 0.
  - Timestamp counter = 0.
- An event written whose head update was lost to reset stays invisible to the CPU.
- Event word format:
  - [31:16] timestamp.
  - [15:9] zero.
  - [8] `key_pressed`.
  - [7:0] `key_code`.
- `key_ready` = 1 only in IDLE; combinational from state.
- Full condition: `((head_ptr + 1) mod BUF_DEPTH) == cons_ptr`. One slot is always left empty; empty is `head_ptr == cons_ptr`.
- FSM states and transitions:
  - IDLE, handshake with buffer not full: latch `data_addr = BUF_BASE + 4*head_ptr` and `data_in` = event word; `mem_req` <= 1; go to WR_EVT.
  - IDLE, handshake with buffer full: event dropped; `overflow_cnt` +1, saturating at 255; stay in IDLE. The keyboard is never back-pressured beyond the FSM busy time.
  - WR_EVT: `wr_en` = `mem_gnt` (combinational).
    - On posedge with `mem_gnt` = 1: memory captures the word; `head_ptr` <= `head_ptr` + 1, wrapping 15 -> 0; `data_addr` <= `HEAD_ADDR`; `data_in` <= zero-extended new head; go to WR_HEAD.
    - `mem_gnt` = 0: hold all outputs and wait indefinitely.
  - WR_HEAD: `wr_en` = `mem_gnt`.
    - On posedge with `mem_gnt` = 1: `mem_req` <= 0; go to IDLE.
    - `mem_gnt` = 0: hold and wait.
- Minimum event-to-visible latency: 3 cycles (accept, event write, head write). Maximum accepted rate: one event per 3 cycles.
- `data_addr`/`data_in` are stable for the whole time `mem_req` = 1; `wr_en` is never high while `mem_req` = 0.
- Full is evaluated against `cons_ptr` as sampled in the accept cycle. A `cons_ptr` change during WR_* has no effect on the in-flight event.
- The timestamp is the free-running counter value in the accept cycle; the counter increments every cycle and wraps at 16 bits.

Optional Feature:
- Macro: `KBD_TIMESTAMP_EN`.
- Defined: 16-bit free-running counter present; bits [31:16] carry the timestamp.
- Undefined: no counter logic; bits [31:16] = 0; all other behaviour identical.

Decomposition:
- Package `kbd_writer_pkg`:
  - FSM state enum (IDLE, WR_EVT, WR_HEAD).
  - Event-word field LSB/width constants: `TS_LSB` = 16, `PRESS_BIT` = 8, `CODE_W` = 8.
  - Default `BUF_BASE`/`HEAD_ADDR` constants.
- Sub-module `kbd_timestamp_ctr`: 16-bit wrapping counter with async reset; instantiated only under `KBD_TIMESTAMP_EN`.

Test Plan:
- Basic write, grant tied 1:
  - Stimulus: `cons_ptr` = 0; event `key_code` = 8'h1C, `key_pressed` = 1.
  - Required: mem[0x1000] = 32'h0000_011C with timestamp masked; mem[0x0FFC] = 1; `head_ptr` = 1; `key_ready` low for exactly 2 cycles.
- Grant stall:
  - Stimulus: `mem_gnt` = 0 for 5 cycles in WR_EVT.
  - Required: `wr_en` = 0 and `data_addr` = 0x1000 held throughout; write completes the cycle grant rises.
- Wrap-around:
  - Stimulus: `cons_ptr` advanced by the bench; 17 events.
  - Required: 16th event lands at 0x103C; 17th at 0x1000; head word goes 15 then 0.
- Full/drop:
  - Stimulus: `cons_ptr` = 0; 15 events, then 3 more.
  - Required: the 3 extra are accepted with no memory write; `overflow_cnt` = 3; `head_ptr` = 15.
- Saturation:
  - Stimulus: 260 events while full.
  - Required: `overflow_cnt` = 255.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously in WR_HEAD.
  - Required: `mem_req`, `wr_en`, `head_ptr` go to 0 immediately (before the next edge); next event writes 0x1000.

Source files
------------

// File: rtl/kbd_event_writer_pkg.sv
// Shared types and constants for the keyboard event writer.
// Defines the FSM state enum, event-word field layout and default buffer addresses.
package kbd_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_EVT  = 2'd1,
        WR_HEAD = 2'd2
    } wr_state_t;

    localparam int TS_LSB    = 16;
    localparam int TS_W      = 16;
    localparam int PRESS_BIT = 8;
    localparam int CODE_W    = 8;

    localparam logic [31:0] DEF_BUF_BASE  = 32'h0000_1000;
    localparam logic [31:0] DEF_HEAD_ADDR = 32'h0000_0FFC;

    // Packs one key event into the memory word layout; unused bits stay zero.
    function automatic logic [31:0] event_word(input logic [TS_W-1:0]   ts,
                                               input logic              pressed,
                                               input logic [CODE_W-1:0] code);
        logic [31:0] w;
        w                  = '0;
        w[TS_LSB +: TS_W]  = ts;
        w[PRESS_BIT]       = pressed;
        w[CODE_W-1:0]      = code;
        return w;
    endfunction

endpackage

// File: rtl/kbd_event_writer_if.sv
// Key-event handshake plus data-port write bus of the keyboard event writer.
// master = the writer block, slave = key-scan logic / memory / arbiter side.
interface kbd_event_writer_if;
    import kbd_writer_pkg::*;

    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              key_pressed;
    logic              key_ready;
    logic              mem_req;
    logic              mem_gnt;
    logic [31:0]       data_addr;
    logic [31:0]       data_in;
    logic              wr_en;

    modport master (
        input  key_valid, key_code, key_pressed, mem_gnt,
        output key_ready, mem_req, data_addr, data_in, wr_en
    );

    modport slave (
        output key_valid, key_code, key_pressed, mem_gnt,
        input  key_ready, mem_req, data_addr, data_in, wr_en
    );

endinterface

// File: rtl/kbd_timestamp_ctr.sv
// Free-running 16-bit event timestamp counter, wraps silently.
// Only instantiated when KBD_TIMESTAMP_EN is defined.
module kbd_timestamp_ctr
    import kbd_writer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic [TS_W-1:0] count
);

    logic [TS_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TS_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/kbd_event_writer.sv
// Writes accepted key events into a circular buffer in data memory, then publishes the head index.
// Optional KBD_TIMESTAMP_EN adds a 16-bit timestamp in bits [31:16] of each event word.
module kbd_event_writer
    import kbd_writer_pkg::*;
#(
    parameter logic [31:0] BUF_BASE  = DEF_BUF_BASE,
    parameter int          BUF_DEPTH = 16,
    parameter logic [31:0] HEAD_ADDR = DEF_HEAD_ADDR,
    parameter int          PTR_W     = $clog2(BUF_DEPTH)
)
(
    input  logic             clk,
    input  logic             reset,
    kbd_event_writer_if.master bus,
    input  logic [PTR_W-1:0] cons_ptr,
    output logic [PTR_W-1:0] head_ptr,
    output logic [7:0]       overflow_cnt
);

    wr_state_t        r_state;
    wr_state_t        w_next_state;
    logic [PTR_W-1:0] r_head;
    logic [7:0]       r_ovf;
    logic             r_mem_req;
    logic [31:0]      r_addr;
    logic [31:0]      r_data;
    logic [TS_W-1:0]  w_ts;
    logic [PTR_W-1:0] w_head_next;
    logic             w_full;
    logic             w_accept;

`ifdef KBD_TIMESTAMP_EN
    kbd_timestamp_ctr u_ts (
        .clk   (clk),
        .reset (reset),
        .count (w_ts)
    );
`else
    assign w_ts = '0;
`endif

    // One slot always stays empty so full and empty remain distinguishable.
    assign w_head_next = r_head + PTR_W'(1);
    assign w_full      = (w_head_next == cons_ptr);
    assign w_accept    = bus.key_valid && (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        bus.key_ready = 1'b0;
        bus.wr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.key_ready = 1'b1;
                if (w_accept && !w_full) begin
                    w_next_state = WR_EVT;
                end
            end
            WR_EVT: begin
                bus.wr_en = bus.mem_gnt;
                if (bus.mem_gnt) begin
                    w_next_state = WR_HEAD;
                end
            end
            WR_HEAD: begin
                bus.wr_en = bus.mem_gnt;
                if (bus.mem_gnt) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Address/data are loaded only on state entry so they hold steady while a grant is pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= '0;
            r_ovf     <= '0;
            r_mem_req <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_full) begin
                            r_addr    <= BUF_BASE + (32'(r_head) << 2);
                            r_data    <= event_word(w_ts, bus.key_pressed, bus.key_code);
                            r_mem_req <= 1'b1;
                        end else if (r_ovf != 8'hFF) begin
                            r_ovf <= r_ovf + 8'd1;
                        end
                    end
                end
                WR_EVT: begin
                    if (bus.mem_gnt) begin
                        r_head <= w_head_next;
                        r_addr <= HEAD_ADDR;
                        r_data <= 32'(w_head_next);
                    end
                end
                WR_HEAD: begin
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.data_addr = r_addr;
    assign bus.data_in   = r_data;
    assign head_ptr      = r_head;
    assign overflow_cnt  = r_ovf;

endmodule
